// File: rtl/gp_writeback_arbiter.sv
// gp_writeback_arbiter
//   Arbitrates the single write port of the 32x32 general-purpose register
//   file between the execute result (req0) and the load result (req1). It
//   also keeps a busy scoreboard of destination registers with an
//   outstanding write, so decode can stall on read-after-write hazards.
//
// Ports
//   clk, rst_n                 rising-edge clock, async active-low reset
//   req0_valid/idx/data/ready  execute-stage result, ready = granted now
//   req1_valid/idx/data/ready  memory-stage result, ready = granted now
//   reserve_valid/idx          decode marks a destination register busy
//   check_idx_1/2, hazard_1/2  decode source lookup, hazard = busy
//   write_idx/data/enable      registered register-file write port
module gp_writeback_arbiter #(
  parameter int ROUND_ROBIN = 1,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic [4:0]      req0_idx,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [4:0]      req1_idx,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  input  logic            reserve_valid,
  input  logic [4:0]      reserve_idx,
  input  logic [4:0]      check_idx_1,
  input  logic [4:0]      check_idx_2,
  output logic            hazard_1,
  output logic            hazard_2,
  output logic [4:0]      write_idx,
  output logic [XLEN-1:0] write_data,
  output logic            write_enable
);

  // One-hot decode of a register index into a scoreboard mask.
  function automatic logic [31:0] idx_mask(input logic [4:0] idx);
    idx_mask = 32'd1 << idx;
  endfunction

  logic        grant0_s;
  logic        grant1_s;
  logic        last_r;      // 1 = req1 received the most recent grant
  logic [31:0] busy_r;
  logic [31:0] set_mask_s;
  logic [31:0] clr_mask_s;

  // Grant selection: a lone requester always wins; on contention either
  // alternate against the last winner or give req0 fixed priority.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid && req1_valid) begin
      if (ROUND_ROBIN != 0) begin
        if (last_r) begin
          grant0_s = 1'b1;
        end else begin
          grant1_s = 1'b1;
        end
      end else begin
        grant0_s = 1'b1;
      end
    end else if (req0_valid) begin
      grant0_s = 1'b1;
    end else if (req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // Round-robin pointer, moves only when somebody is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= 1'b1;
    end else if (grant0_s || grant1_s) begin
      last_r <= grant1_s;
    end else begin
      last_r <= last_r;
    end
  end

  // Registered write port; index and data hold when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_enable <= 1'b0;
      write_idx    <= 5'd0;
      write_data   <= {XLEN{1'b0}};
    end else if (grant0_s) begin
      write_enable <= 1'b1;
      write_idx    <= req0_idx;
      write_data   <= req0_data;
    end else if (grant1_s) begin
      write_enable <= 1'b1;
      write_idx    <= req1_idx;
      write_data   <= req1_data;
    end else begin
      write_enable <= 1'b0;
      write_idx    <= write_idx;
      write_data   <= write_data;
    end
  end

  // Scoreboard set/clear masks; x0 is never marked busy.
  always_comb begin
    set_mask_s = 32'd0;
    clr_mask_s = 32'd0;
    if (reserve_valid && (reserve_idx != 5'd0)) begin
      set_mask_s = idx_mask(reserve_idx);
    end else begin
      set_mask_s = 32'd0;
    end
    if (write_enable) begin
      clr_mask_s = idx_mask(write_idx);
    end else begin
      clr_mask_s = 32'd0;
    end
  end

  // Busy bits: the clear lands on the commit edge, and a reservation on
  // that same edge wins because it belongs to a newer producer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 32'd0;
    end else begin
      busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
    end
  end

  // No bypass from the output stage: a committing register stays
  // hazardous until the cycle after its write_enable.
  assign hazard_1 = busy_r[check_idx_1] & (check_idx_1 != 5'd0);
  assign hazard_2 = busy_r[check_idx_2] & (check_idx_2 != 5'd0);

endmodule

// File: tb/tb_gp_writeback_arbiter.sv
// Bench for gp_writeback_arbiter. Two instances: index 0 is round-robin,
// index 1 is fixed priority. A reference model per instance (a busy array,
// the last winner and the pending register-file write) is checked against
// every output on each falling edge; directed sections add literal checks.
module tb_gp_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  v0, v1, rdy0, rdy1, we, h1, h2;
  logic [4:0]  i0 [2];
  logic [4:0]  i1 [2];
  logic [4:0]  widx [2];
  logic [31:0] d0 [2];
  logic [31:0] d1 [2];
  logic [31:0] wdata [2];
  logic        rv;
  logic [4:0]  ridx, c1, c2;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  bit          m_busy [2][32];
  bit          m_last1 [2] = '{1'b1, 1'b1};
  bit          m_we [2];
  logic [4:0]  m_widx [2];
  logic [31:0] m_wdata [2];
  bit          m_g0 [2];
  bit          m_g1 [2];

  always #5 clk = ~clk;

  gp_writeback_arbiter #(.ROUND_ROBIN(1), .XLEN(32)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0[0]), .req0_idx(i0[0]), .req0_data(d0[0]), .req0_ready(rdy0[0]),
    .req1_valid(v1[0]), .req1_idx(i1[0]), .req1_data(d1[0]), .req1_ready(rdy1[0]),
    .reserve_valid(rv), .reserve_idx(ridx),
    .check_idx_1(c1), .check_idx_2(c2), .hazard_1(h1[0]), .hazard_2(h2[0]),
    .write_idx(widx[0]), .write_data(wdata[0]), .write_enable(we[0])
  );

  gp_writeback_arbiter #(.ROUND_ROBIN(0), .XLEN(32)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0[1]), .req0_idx(i0[1]), .req0_data(d0[1]), .req0_ready(rdy0[1]),
    .req1_valid(v1[1]), .req1_idx(i1[1]), .req1_data(d1[1]), .req1_ready(rdy1[1]),
    .reserve_valid(rv), .reserve_idx(ridx),
    .check_idx_1(c1), .check_idx_2(c2), .hazard_1(h1[1]), .hazard_2(h2[1]),
    .write_idx(widx[1]), .write_data(wdata[1]), .write_enable(we[1])
  );

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare process: every falling edge, check both instances, then advance
  // the model to what the coming rising edge must produce.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int r = 0; r < 32; r++) m_busy[k][r] = 1'b0;
        m_last1[k] = 1'b1;
        m_we[k]    = 1'b0;
        m_widx[k]  = 5'd0;
        m_wdata[k] = 32'd0;
      end
      if (v0[k] && v1[k]) begin
        if (k == 0) m_g0[k] = m_last1[k];
        else        m_g0[k] = 1'b1;
      end else begin
        m_g0[k] = v0[k];
      end
      m_g1[k] = v1[k] && !m_g0[k];

      chk("req0_ready", k, rdy0[k], m_g0[k]);
      chk("req1_ready", k, rdy1[k], m_g1[k]);
      chk("write_enable", k, we[k], m_we[k]);
      chk("write_idx", k, widx[k], m_widx[k]);
      chk("write_data", k, wdata[k], m_wdata[k]);
      chk("hazard_1", k, h1[k], m_busy[k][c1] && (c1 != 5'd0));
      chk("hazard_2", k, h2[k], m_busy[k][c2] && (c2 != 5'd0));

      if (rst_n) begin
        if (m_we[k]) m_busy[k][m_widx[k]] = 1'b0;
        if (rv && ridx != 5'd0) m_busy[k][ridx] = 1'b1;
        if (m_g0[k]) begin
          m_we[k] = 1'b1; m_widx[k] = i0[k]; m_wdata[k] = d0[k];
        end else if (m_g1[k]) begin
          m_we[k] = 1'b1; m_widx[k] = i1[k]; m_wdata[k] = d1[k];
        end else begin
          m_we[k] = 1'b0;
        end
        if (m_g0[k] || m_g1[k]) m_last1[k] = m_g1[k];
      end
    end
  end

  initial begin
    v0 = 2'b00; v1 = 2'b00; rv = 1'b0; ridx = 5'd0; c1 = 5'd0; c2 = 5'd0;
    for (int k = 0; k < 2; k++) begin
      i0[k] = 5'd0; i1[k] = 5'd0; d0[k] = 32'd0; d1[k] = 32'd0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_we", 0, we[0], 32'd0);
    chk("rst_widx", 0, widx[0], 32'd0);
    chk("rst_rdy0", 0, rdy0[0], 32'd0);
    tick();
    rst_n = 1'b1;

    // contention: round-robin alternates 1,2,1,2; fixed priority stays on 1
    tick();
    for (int k = 0; k < 2; k++) begin
      v0[k] = 1'b1; i0[k] = 5'd1; d0[k] = 32'h1111_0001;
      v1[k] = 1'b1; i1[k] = 5'd2; d1[k] = 32'h2222_0002;
    end
    for (int c = 0; c < 5; c++) begin
      #2;
      chk("cont_rdy0", 0, rdy0[0], (c % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_rdy0_fp", 1, rdy0[1], 32'd1);
      if (c > 0) begin
        chk("cont_widx", 0, widx[0], (c % 2 == 1) ? 32'd1 : 32'd2);
        chk("cont_widx_fp", 1, widx[1], 32'd1);
        chk("cont_we", 0, we[0], 32'd1);
      end
      tick();
    end
    v0 = 2'b00;
    tick();
    v1 = 2'b00;

    // single request with one-cycle latency
    tick();
    v0[0] = 1'b1; i0[0] = 5'd5; d0[0] = 32'hDEAD_BEEF;
    #2 chk("single_rdy0", 0, rdy0[0], 32'd1);
    tick();
    v0[0] = 1'b0;
    #2;
    chk("single_we", 0, we[0], 32'd1);
    chk("single_widx", 0, widx[0], 32'd5);
    chk("single_wdata", 0, wdata[0], 32'hDEAD_BEEF);
    tick();
    #2 chk("single_we_drop", 0, we[0], 32'd0);

    // scoreboard: reserve 7, write 7 from req1, hazard clears a cycle later
    tick();
    rv = 1'b1; ridx = 5'd7;
    tick();
    rv = 1'b0; c1 = 5'd7;
    #2 chk("sb_haz_set", 0, h1[0], 32'd1);
    tick();
    v1[0] = 1'b1; i1[0] = 5'd7; d1[0] = 32'hCAFE_0007;
    #2 chk("sb_rdy1", 0, rdy1[0], 32'd1);
    tick();
    v1[0] = 1'b0;
    #2;
    chk("sb_we", 0, we[0], 32'd1);
    chk("sb_widx", 0, widx[0], 32'd7);
    chk("sb_haz_during_write", 0, h1[0], 32'd1);
    tick();
    #2 chk("sb_haz_cleared", 0, h1[0], 32'd0);
    tick();
    rv = 1'b1; ridx = 5'd0; c2 = 5'd0;
    tick();
    rv = 1'b0;
    #2 chk("sb_x0_never_busy", 0, h2[0], 32'd0);

    // same-edge set and clear of idx 3: the reservation wins
    tick();
    rv = 1'b1; ridx = 5'd3;
    tick();
    rv = 1'b0; v0[0] = 1'b1; i0[0] = 5'd3; d0[0] = 32'h0000_0333;
    tick();
    v0[0] = 1'b0; rv = 1'b1; ridx = 5'd3;
    #2 chk("setclr_widx", 0, widx[0], 32'd3);
    tick();
    rv = 1'b0; c1 = 5'd3;
    #2 chk("setclr_busy", 0, h1[0], 32'd1);

    // asynchronous reset with a write in flight and busy[4] set
    tick();
    rv = 1'b1; ridx = 5'd4;
    tick();
    rv = 1'b0; c2 = 5'd4; v0[0] = 1'b1; i0[0] = 5'd9; d0[0] = 32'h9;
    #2 chk("mid_busy4", 0, h2[0], 32'd1);
    tick();
    i0[0] = 5'd10;
    #1;
    rst_n = 1'b0; v0[0] = 1'b0;
    #1;
    chk("mid_we_drop", 0, we[0], 32'd0);
    chk("mid_busy_clear", 0, h2[0], 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #2;
    chk("mid_post_we", 0, we[0], 32'd0);
    chk("mid_post_widx", 0, widx[0], 32'd0);
    tick();
    #2 chk("mid_post_we2", 0, we[0], 32'd0);

    // randomized traffic; an ungranted request is held stable
    repeat (3000) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if (!(v0[k] && !m_g0[k])) begin
          v0[k] = ($urandom_range(2) != 0);
          i0[k] = 5'($urandom_range(31));
          d0[k] = $urandom;
        end
        if (!(v1[k] && !m_g1[k])) begin
          v1[k] = ($urandom_range(2) != 0);
          i1[k] = 5'($urandom_range(31));
          d1[k] = $urandom;
        end
      end
      rv   = ($urandom_range(2) == 0);
      ridx = 5'($urandom_range(31));
      c1   = 5'($urandom_range(31));
      c2   = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
    end
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
